// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: register indices, PC-select codes and the
// pipeline controller state encoding.
package cpu_types_pkg;

  // Register file index (32 architectural registers, r0 hard-wired to zero).
  typedef logic [4:0] regbits_t;

  // Next-PC source selected by the instruction resolving in MEM.
  typedef enum logic [1:0] {
    NEXT   = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    JUMPR  = 2'd3
  } pc_select_t;

  // Pipeline controller sequencing states.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HALT_DRAIN = 2'd1,
    HALTED     = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an instruction in ID that reads the destination
// of a load still sitting in EX. Purely combinational.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_dREN,
  input  regbits_t idex_wsel,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     load_use
);

  // r0 never carries a value, so a load targeting it cannot create a hazard.
  assign load_use = idex_dREN && (idex_wsel != '0) &&
                    ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline. Produces the
// enable/flush pair for every pipeline latch plus the PC enable, sequences the
// halt drain, and keeps saturating stall/redirect counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_halt,
  input  pc_select_t       exmem_pc_select,
  input  logic             idex_dREN,
  input  regbits_t         idex_wsel,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic             exmem_flush,
  output logic             memwb_enable,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] redirect_count
);

  pipe_state_t state, next_state;
  logic        load_use;
  logic        d_stall;
  logic        redirect_inc;

  hazard_detect u_hazard_detect (
    .idex_dREN (idex_dREN),
    .idex_wsel (idex_wsel),
    .ifid_rs   (ifid_rs),
    .ifid_rt   (ifid_rt),
    .load_use  (load_use)
  );

  assign d_stall = (exmem_dREN || exmem_dWEN) && !dhit;

  // Priority mux: state plus current inputs select every latch control (Mealy).
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pc_enable    = 1'b0;
    ifid_enable  = 1'b0;
    ifid_flush   = 1'b0;
    idex_enable  = 1'b0;
    idex_flush   = 1'b0;
    exmem_enable = 1'b0;
    exmem_flush  = 1'b0;
    memwb_enable = 1'b0;
    memwb_flush  = 1'b0;
    halt         = 1'b0;
    redirect_inc = 1'b0;
    next_state   = state;

    // While reset is held every control stays low.
    if (nRST) begin
      unique case (state)
        RUN: begin
          if (exmem_halt) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_enable = 1'b1;
            next_state   = HALT_DRAIN;
          end else if (d_stall || (exmem_pc_select != NEXT && !ihit)) begin
            // Upstream holds; a bubble enters WB. A redirect waiting on its
            // fetch takes the same shape so the branch stays parked in MEM.
            memwb_enable = 1'b1;
            memwb_flush  = 1'b1;
          end else if (exmem_pc_select != NEXT) begin
            pc_enable    = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_enable = 1'b1;
            redirect_inc = 1'b1;
          end else if (load_use) begin
            idex_enable  = 1'b1;
            idex_flush   = 1'b1;
            exmem_enable = 1'b1;
            memwb_enable = 1'b1;
          end else if (!ihit) begin
            ifid_enable  = 1'b1;
            ifid_flush   = 1'b1;
            idex_enable  = 1'b1;
            exmem_enable = 1'b1;
            memwb_enable = 1'b1;
          end else begin
            pc_enable    = 1'b1;
            ifid_enable  = 1'b1;
            idex_enable  = 1'b1;
            exmem_enable = 1'b1;
            memwb_enable = 1'b1;
          end
        end
        HALT_DRAIN: begin
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          exmem_flush  = 1'b1;
          memwb_enable = 1'b1;
          next_state   = HALTED;
        end
        HALTED: begin
          halt = 1'b1;
        end
        default: begin
          next_state = RUN;
        end
      endcase
    end
  end

  // State register; reset always returns to RUN, never resumes a drain.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  // Saturating performance counters, frozen outside RUN.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_count    <= '0;
      redirect_count <= '0;
    end else if (state == RUN) begin
      if (!pc_enable && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (redirect_inc && (redirect_count != '1))
        redirect_count <= redirect_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a table of single-cycle RUN vectors
// followed by hand-written multi-cycle sequences (stalls, redirect, halt,
// reset, counter saturation).
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Packed view: {pc, ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl, halt}
  localparam logic [9:0] O_ZERO   = 10'b0_00_00_00_00_0;
  localparam logic [9:0] O_RUN    = 10'b1_10_10_10_10_0;
  localparam logic [9:0] O_DSTALL = 10'b0_00_00_00_11_0;
  localparam logic [9:0] O_REDIR  = 10'b1_01_01_01_10_0;
  localparam logic [9:0] O_LU     = 10'b0_00_11_10_10_0;
  localparam logic [9:0] O_IMISS  = 10'b0_11_10_10_10_0;
  localparam logic [9:0] O_HALT1  = 10'b0_01_01_01_10_0;
  localparam logic [9:0] O_HALTED = 10'b0_00_00_00_00_1;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, idex_dREN;
  pc_select_t exmem_pc_select;
  regbits_t idex_wsel, ifid_rs, ifid_rt;
  logic pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic exmem_enable, exmem_flush, memwb_enable, memwb_flush, halt;
  logic [CNT_W-1:0] stall_count, redirect_count;
  logic [9:0] outs;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .ihit            (ihit),
    .dhit            (dhit),
    .exmem_dREN      (exmem_dREN),
    .exmem_dWEN      (exmem_dWEN),
    .exmem_halt      (exmem_halt),
    .exmem_pc_select (exmem_pc_select),
    .idex_dREN       (idex_dREN),
    .idex_wsel       (idex_wsel),
    .ifid_rs         (ifid_rs),
    .ifid_rt         (ifid_rt),
    .pc_enable       (pc_enable),
    .ifid_enable     (ifid_enable),
    .ifid_flush      (ifid_flush),
    .idex_enable     (idex_enable),
    .idex_flush      (idex_flush),
    .exmem_enable    (exmem_enable),
    .exmem_flush     (exmem_flush),
    .memwb_enable    (memwb_enable),
    .memwb_flush     (memwb_flush),
    .halt            (halt),
    .stall_count     (stall_count),
    .redirect_count  (redirect_count)
  );

  assign outs = {pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
                 exmem_enable, exmem_flush, memwb_enable, memwb_flush, halt};

  typedef struct {
    string      name;
    logic       ihit, dhit, dren, dwen;
    pc_select_t sel;
    logic       ld;
    regbits_t   wsel, rs, rt;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ih, input logic dh, input logic dr, input logic dw,
                       input logic hl, input pc_select_t sel, input logic ld,
                       input regbits_t ws, input regbits_t rs, input regbits_t rt);
    ihit = ih; dhit = dh; exmem_dREN = dr; exmem_dWEN = dw; exmem_halt = hl;
    exmem_pc_select = sel; idex_dREN = ld; idex_wsel = ws; ifid_rs = rs; ifid_rt = rt;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NEXT, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic drive_random();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          pc_select_t'($urandom_range(0, 3)), 1'($urandom),
          5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reset pulse, returning just after a rising edge with reset released.
  task automatic do_reset();
    idle();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  function automatic vec_t mk(string n, logic ih, logic dh, logic dr, logic dw,
                              pc_select_t s, logic ld, regbits_t ws, regbits_t rs,
                              regbits_t rt, logic [9:0] e);
    vec_t v;
    v.name = n; v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw; v.sel = s;
    v.ld = ld; v.wsel = ws; v.rs = rs; v.rt = rt; v.exp = e;
    return v;
  endfunction

  initial begin
    int exp_stall;
    int exp_redir;

    vecs[0]  = mk("normal",         1, 0, 0, 0, NEXT,   0, 0, 0, 0, O_RUN);
    vecs[1]  = mk("imiss",          0, 0, 0, 0, NEXT,   0, 0, 0, 0, O_IMISS);
    vecs[2]  = mk("dstall_rd",      1, 0, 1, 0, NEXT,   0, 0, 0, 0, O_DSTALL);
    vecs[3]  = mk("dstall_wr",      1, 0, 0, 1, NEXT,   0, 0, 0, 0, O_DSTALL);
    vecs[4]  = mk("dhit_rd",        1, 1, 1, 0, NEXT,   0, 0, 0, 0, O_RUN);
    vecs[5]  = mk("redir_ihit",     1, 0, 0, 0, BRANCH, 0, 0, 0, 0, O_REDIR);
    vecs[6]  = mk("redir_imiss",    0, 0, 0, 0, JUMP,   0, 0, 0, 0, O_DSTALL);
    vecs[7]  = mk("redir_dhit",     1, 1, 1, 0, JUMPR,  0, 0, 0, 0, O_REDIR);
    vecs[8]  = mk("lu_rs",          1, 0, 0, 0, NEXT,   1, 5, 5, 0, O_LU);
    vecs[9]  = mk("lu_r0",          1, 0, 0, 0, NEXT,   1, 0, 0, 0, O_RUN);
    vecs[10] = mk("lu_over_imiss",  0, 0, 0, 0, NEXT,   1, 9, 3, 9, O_LU);
    vecs[11] = mk("no_load",        1, 0, 0, 0, NEXT,   0, 5, 5, 5, O_RUN);
    vecs[12] = mk("dstall_over_lu", 1, 0, 1, 0, NEXT,   1, 5, 5, 0, O_DSTALL);
    vecs[13] = mk("redir_over_lu",  1, 0, 0, 0, BRANCH, 1, 5, 5, 0, O_REDIR);
    vecs[14] = mk("lu_rt",          1, 0, 0, 0, NEXT,   1, 7, 1, 7, O_LU);

    // Reset state: outputs forced low, counters cleared.
    idle();
    nRST = 1'b0;
    #2;
    check("reset_outs", 32'(outs), 32'(O_ZERO));
    check("reset_stall", 32'(stall_count), 32'd0);
    check("reset_redir", 32'(redirect_count), 32'd0);
    tick();
    nRST = 1'b1;
    tick();

    // Table-driven single-cycle vectors, all in RUN.
    exp_stall = 0;
    exp_redir = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].ihit, vecs[i].dhit, vecs[i].dren, vecs[i].dwen, 1'b0, vecs[i].sel,
            vecs[i].ld, vecs[i].wsel, vecs[i].rs, vecs[i].rt);
      @(negedge CLK);
      check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
      if (!vecs[i].exp[9]) exp_stall++;
      if (vecs[i].exp == O_REDIR) exp_redir++;
      tick();
    end
    idle();
    @(negedge CLK);
    check("table_stall_cnt", 32'(stall_count), 32'(exp_stall));
    check("table_redir_cnt", 32'(redirect_count), 32'(exp_redir));

    // Asynchronous reset mid-run (mid-stall): outputs drop immediately.
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NEXT, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    nRST = 1'b0;
    #1;
    check("async_rst_outs", 32'(outs), 32'(O_ZERO));
    check("async_rst_stall", 32'(stall_count), 32'd0);
    check("async_rst_redir", 32'(redirect_count), 32'd0);
    do_reset();

    // D-stall for three cycles, then dhit.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NEXT, 1'b0, 5'd0, 5'd0, 5'd0);
      @(negedge CLK);
      check($sformatf("dstall_seq_%0d", c), 32'(outs), 32'(O_DSTALL));
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NEXT, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    check("dstall_seq_release", 32'(outs), 32'(O_RUN));
    check("dstall_seq_count", 32'(stall_count), 32'd3);
    tick();

    // Redirect waiting on a fetch miss for two cycles, then accepted.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BRANCH, 1'b0, 5'd0, 5'd0, 5'd0);
      @(negedge CLK);
      check($sformatf("redir_wait_%0d", c), 32'(outs), 32'(O_DSTALL));
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BRANCH, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    check("redir_take", 32'(outs), 32'(O_REDIR));
    tick();
    idle();
    @(negedge CLK);
    check("redir_count", 32'(redirect_count), 32'd1);
    check("redir_stall_count", 32'(stall_count), 32'd2);

    // Halt: flush, one drain cycle, then halted until reset.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NEXT, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    check("halt_cycle1", 32'(outs), 32'(O_HALT1));
    tick();
    drive_random();
    @(negedge CLK);
    check("halt_drain", 32'(outs), 32'(O_HALT1));
    tick();
    for (int c = 0; c < 10; c++) begin
      drive_random();
      @(negedge CLK);
      check($sformatf("halted_%0d", c), 32'(outs), 32'(O_HALTED));
      tick();
    end
    check("halted_stall_frozen", 32'(stall_count), 32'd1);
    check("halted_redir_frozen", 32'(redirect_count), 32'd0);

    // Reset during the drain cycle returns to RUN.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NEXT, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    idle();
    #2;
    nRST = 1'b0;
    #1;
    check("drain_rst_outs", 32'(outs), 32'(O_ZERO));
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    check("drain_rst_run", 32'(outs), 32'(O_RUN));
    tick();

    // Long D-stall drives the stall counter into saturation.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, NEXT, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int c = 0; c < 40; c++) tick();
    @(negedge CLK);
    check("sat_stall", 32'(stall_count), 32'(CNT_MAX));
    tick();
    @(negedge CLK);
    check("sat_no_wrap", 32'(stall_count), 32'(CNT_MAX));
    check("sat_redir_zero", 32'(redirect_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
